cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Common Data Bus (CDB) arbiter, directly downstream of the ALU reservation station and the other execution units (branch unit, load/store unit).
- Buffers each unit's completed result in a small per-source FIFO.
- Each cycle, picks one result round-robin and broadcasts it as a registered CDB value (valid, lock index, result).
- The broadcast feeds back to every reservation station as cdb_in_index/cdb_in_result, and to the register file.

Parameters:
- N_SRC, 3, number of execution-unit sources (0 = ALU, 1 = branch, 2 = load/store).
- FIFO_DEPTH, 2, entries per source FIFO; power of two, minimum 2.
- LOCK_W, 5, register-lock (tag) index width; value 0 means "no lock".
- DATA_W, 32, result width.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-low reset; acts on the rising edge of clk while rst==0.
- flush, input, 1, synchronous pipeline flush; active-high; priority below rst.
- src_valid, input, N_SRC, bit s set: source s presents a completed result this cycle.
- src_index, input, N_SRC*LOCK_W, lock index of source s in bits [s*LOCK_W +: LOCK_W].
- src_result, input, N_SRC*DATA_W, result of source s in bits [s*DATA_W +: DATA_W].
- src_stall, output, N_SRC, bit s set: FIFO s is full; source s must hold its result and retry.
- cdb_valid, output, 1, registered broadcast valid.
- cdb_index, output, LOCK_W, registered broadcast lock index.
- cdb_result, output, DATA_W, registered broadcast result.

Behaviour:
- Reset (rst==0 at clk edge):
  - all FIFOs emptied (read/write pointers and counts = 0);
  - rr_ptr = 0;
  - cdb_valid = 0, cdb_index = 0, cdb_result = 0.
  - src_stall is combinational from the counts, so it reads 0 from the first cycle after reset.
  - Reset mid-operation discards all buffered results.
- Flush (rst==1, flush==1):
  - same clearing as reset, except rr_ptr is held;
  - pushes and pops in that cycle are ignored.
- src_stall[s] = (count[s] == FIFO_DEPTH).
  - Combinational from registered state only; no bypass from same-cycle pop.
  - A full FIFO refuses a push even when it is popped in the same cycle.
- Push:
  - Condition: src_valid[s] && !src_stall[s] && src_index slice != 0.
  - Writes {index, result} at wptr[s]; wptr wraps modulo FIFO_DEPTH.
  - src_valid with index 0 is silently dropped and does not count as a push.
- Arbitration:
  - Candidates are FIFOs with count != 0 at the start of the cycle, so an entry pushed this cycle is never granted this cycle.
  - The winner is the first non-empty source scanning rr_ptr, rr_ptr+1, ... modulo N_SRC.
- Grant:
  - Pops the winner's head (rptr wraps).
  - Next edge: cdb_valid = 1, cdb_index = head index, cdb_result = head result.
  - rr_ptr = (winner + 1) mod N_SRC.
- No candidate: next edge cdb_valid = 0, cdb_index = 0, cdb_result = 0; rr_ptr unchanged.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, both pointers advance.
- Ordering: results from one source leave in arrival order. There is no ordering guarantee across sources.
- Latency: src_valid accepted at edge N → earliest cdb_valid at edge N+1's output, i.e. visible the cycle after acceptance (minimum 2 cycles from presentation to broadcast in a pipelined view).
- Throughput: one broadcast per cycle when any FIFO is non-empty.
- cdb_* outputs are fully registered; no combinational path from src_* to cdb_*.

Test Plan:
- Reset: hold rst=0 for 2 cycles with src_valid=3'b111 → cdb_valid=0, cdb_index=0, cdb_result=0, src_stall=0 after release; nothing broadcast afterwards.
- Single source: ALU pushes index 5, result 32'h0000_0007 → cdb_valid=1, index=5, result=7 exactly one cycle later; next cycle cdb_valid=0.
- Round-robin: all three sources push in one cycle (indices 1, 2, 3) with rr_ptr=0 → broadcasts in order 1, 2, 3 on consecutive cycles; a further push from source 0 (index 4) and source 2 (index 6) → 6 is granted before 4.
- Full/stall: source 0 pushes 3 consecutive cycles (indices 7, 8, 9) while sources 1 and 2 win arbitration → src_stall[0]=1 after 2 entries; the index 9 push is refused until stall drops; FIFO order 7, 8 is preserved.
- Index 0 drop: src_valid[1]=1 with index 0 → no broadcast; count unchanged.
- Flush: two entries buffered, assert flush for 1 cycle → cdb_valid=0 the next cycle, all counts 0, src_stall=0, rr_ptr unchanged.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers completed results from each execution unit
// in a small per-source FIFO and broadcasts one result per cycle, chosen
// round-robin, on a registered CDB (valid, lock index, result).
//
// Source handshake: a source presents a result by raising src_valid[s] with
// src_index/src_result for that slot. The result is taken on the rising edge
// when src_stall[s] is low and the lock index is non-zero. While src_stall[s]
// is high the source must hold its result and present it again. A zero lock
// index is dropped silently. src_stall depends only on registered FIFO
// occupancy, so a same-cycle pop never frees a slot for a same-cycle push.
module cdb_arbiter #(
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int LOCK_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*LOCK_W-1:0] src_index,
    input  logic [N_SRC*DATA_W-1:0] src_result,
    output logic [N_SRC-1:0]        src_stall,
    output logic                    cdb_valid,
    output logic [LOCK_W-1:0]       cdb_index,
    output logic [DATA_W-1:0]       cdb_result
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int ENT_W = LOCK_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // FIFO storage; each entry is {lock index, result}
    logic [ENT_W-1:0] mem_q [N_SRC][FIFO_DEPTH];

    logic [PTR_W-1:0] wptr_q [N_SRC];
    logic [PTR_W-1:0] wptr_d [N_SRC];
    logic [PTR_W-1:0] rptr_q [N_SRC];
    logic [PTR_W-1:0] rptr_d [N_SRC];
    logic [CNT_W-1:0] cnt_q  [N_SRC];
    logic [CNT_W-1:0] cnt_d  [N_SRC];

    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] rr_ptr_d;

    logic              cdb_valid_q;
    logic              cdb_valid_d;
    logic [LOCK_W-1:0] cdb_index_q;
    logic [LOCK_W-1:0] cdb_index_d;
    logic [DATA_W-1:0] cdb_result_q;
    logic [DATA_W-1:0] cdb_result_d;

    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic             grant;
    logic [SRC_W-1:0] winner;
    logic [SRC_W:0]   cand_sum;
    logic [SRC_W-1:0] cand;
    logic [ENT_W-1:0] head;

    assign cdb_valid  = cdb_valid_q;
    assign cdb_index  = cdb_index_q;
    assign cdb_result = cdb_result_q;

    // Stall when full, and accept a push only for a non-zero lock index
    always_comb begin
        src_stall = '0;
        push      = '0;
        for (int s = 0; s < N_SRC; s++) begin
            src_stall[s] = (cnt_q[s] == FULL_CNT);
            push[s]      = src_valid[s] && (cnt_q[s] != FULL_CNT) &&
                           (src_index[s*LOCK_W +: LOCK_W] != '0);
        end
    end

    // Round-robin scan from rr_ptr over FIFOs non-empty at the start of the cycle
    always_comb begin
        grant    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (cand_sum >= (SRC_W+1)'(N_SRC)) begin
                cand_sum = cand_sum - (SRC_W+1)'(N_SRC);
            end
            cand = cand_sum[SRC_W-1:0];
            if (!grant && (cnt_q[cand] != '0)) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
    end

    // Per-FIFO pointer and occupancy update; push and pop together keep the count
    always_comb begin
        pop = '0;
        for (int s = 0; s < N_SRC; s++) begin
            pop[s]    = grant && (winner == SRC_W'(s));
            wptr_d[s] = wptr_q[s];
            rptr_d[s] = rptr_q[s];
            cnt_d[s]  = cnt_q[s];
            if (push[s]) begin
                wptr_d[s] = wptr_q[s] + PTR_W'(1);
            end
            if (pop[s]) begin
                rptr_d[s] = rptr_q[s] + PTR_W'(1);
            end
            case ({push[s], pop[s]})
                2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
                2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
                default: cnt_d[s] = cnt_q[s];
            endcase
        end
    end

    // Next CDB broadcast and round-robin pointer; idle cycles drive zeros
    always_comb begin
        cdb_valid_d  = 1'b0;
        cdb_index_d  = '0;
        cdb_result_d = '0;
        rr_ptr_d     = rr_ptr_q;
        head         = '0;
        if (grant) begin
            head         = mem_q[winner][rptr_q[winner]];
            cdb_valid_d  = 1'b1;
            cdb_index_d  = head[ENT_W-1 -: LOCK_W];
            cdb_result_d = head[DATA_W-1:0];
            rr_ptr_d     = (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
        end
    end

    // FIFO storage write; reset and flush only clear pointers, never the data
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (push[s]) begin
                    mem_q[s][wptr_q[s]] <= {src_index[s*LOCK_W +: LOCK_W],
                                            src_result[s*DATA_W +: DATA_W]};
                end
            end
        end
    end

    // State registers: reset clears everything, flush clears all but rr_ptr
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < N_SRC; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_index_q  <= '0;
            cdb_result_q <= '0;
        end else if (flush) begin
            for (int s = 0; s < N_SRC; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            cdb_valid_q  <= 1'b0;
            cdb_index_q  <= '0;
            cdb_result_q <= '0;
        end else begin
            for (int s = 0; s < N_SRC; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
                cnt_q[s]  <= cnt_d[s];
            end
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_index_q  <= cdb_index_d;
            cdb_result_q <= cdb_result_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based reference model through an expected-value queue.
module tb_cdb_arbiter;

    localparam int N_SRC      = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int LOCK_W     = 5;
    localparam int DATA_W     = 32;
    localparam int ENT_W      = LOCK_W + DATA_W;
    localparam int EXP_W      = 1 + ENT_W;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*LOCK_W-1:0] src_index;
    logic [N_SRC*DATA_W-1:0] src_result;
    logic [N_SRC-1:0]        src_stall;
    logic                    cdb_valid;
    logic [LOCK_W-1:0]       cdb_index;
    logic [DATA_W-1:0]       cdb_result;

    cdb_arbiter #(
        .N_SRC     (N_SRC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LOCK_W    (LOCK_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_index (src_index),
        .src_result(src_result),
        .src_stall (src_stall),
        .cdb_valid (cdb_valid),
        .cdb_index (cdb_index),
        .cdb_result(cdb_result)
    );

    // Clock and initial input levels
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        src_valid  = '0;
        src_index  = '0;
        src_result = '0;
    end

    // Scoreboard state
    int n_pass  = 0;
    int n_total = 0;
    logic [EXP_W-1:0] exp_q[$];
    int               bcast_log[$];
    logic [N_SRC-1:0] obs_stall;

    // Reference model: one plain queue per source plus a round-robin start
    logic [ENT_W-1:0] mq [N_SRC][$];
    int               m_rr = 0;
    bit               model_known = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [N_SRC-1:0] model_stall();
        logic [N_SRC-1:0] r;
        r = '0;
        for (int s = 0; s < N_SRC; s++) r[s] = (mq[s].size() == FIFO_DEPTH);
        return r;
    endfunction

    // Advance the model by one clock edge and queue the CDB value it implies
    task automatic model_step(input logic [N_SRC-1:0] v, input logic [N_SRC*LOCK_W-1:0] idx,
                              input logic [N_SRC*DATA_W-1:0] res, input logic r, input logic f);
        bit               found;
        int               w;
        int               s;
        bit [N_SRC-1:0]   acc;
        logic [ENT_W-1:0] e;
        if (!r || f) begin
            for (int i = 0; i < N_SRC; i++) mq[i].delete();
            if (!r) m_rr = 0;
            exp_q.push_back('0);
            model_known = 1'b1;
            return;
        end
        found = 1'b0;
        w = 0;
        for (int k = 0; k < N_SRC; k++) begin
            s = (m_rr + k) % N_SRC;
            if (!found && mq[s].size() != 0) begin
                found = 1'b1;
                w = s;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            acc[i] = v[i] && (mq[i].size() < FIFO_DEPTH) && (idx[i*LOCK_W +: LOCK_W] != '0);
        end
        if (found) begin
            e = mq[w].pop_front();
            exp_q.push_back({1'b1, e});
            m_rr = (w + 1) % N_SRC;
        end else begin
            exp_q.push_back('0);
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (acc[i]) mq[i].push_back({idx[i*LOCK_W +: LOCK_W], res[i*DATA_W +: DATA_W]});
        end
    endtask

    // Driver: one cycle of stimulus applied at the falling edge
    task automatic cycle(input logic [N_SRC-1:0] v, input logic [N_SRC*LOCK_W-1:0] idx,
                         input logic [N_SRC*DATA_W-1:0] res, input logic r, input logic f);
        @(negedge clk);
        obs_stall = src_stall;
        if (model_known) check("src_stall", 64'(src_stall), 64'(model_stall()));
        rst        = r;
        flush      = f;
        src_valid  = v;
        src_index  = idx;
        src_result = res;
        model_step(v, idx, res, r, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_log(input string name, input int want[$]);
        check({name, "_len"}, 64'(bcast_log.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < bcast_log.size(); i++) begin
            check(name, 64'(bcast_log[i]), 64'(want[i]));
        end
    endtask

    // Monitor: compare every post-edge CDB value with the next expectation
    always @(posedge clk) begin
        logic [EXP_W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cdb", 64'({cdb_valid, cdb_index, cdb_result}), 64'(e));
            if (cdb_valid) bcast_log.push_back(int'(cdb_index));
        end
    end

    // Safety limit so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Stimulus sequence
    initial begin
        int want[$];
        logic [N_SRC-1:0]        v;
        logic [N_SRC*LOCK_W-1:0] idx;

        // Reset held with all sources presenting
        cycle(3'b111, {5'd3, 5'd2, 5'd1}, {$urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        cycle(3'b111, {5'd3, 5'd2, 5'd1}, {$urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        bcast_log.delete();
        idle(4);
        settle();
        check("reset_cdb", 64'({cdb_valid, cdb_index, cdb_result}), 64'd0);
        check("reset_stall", 64'(obs_stall), 64'd0);
        want.delete();
        check_log("reset_quiet", want);

        // Single ALU result
        bcast_log.delete();
        cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'h0000_0007}, 1'b1, 1'b0);
        idle(3);
        settle();
        want = '{5};
        check_log("single", want);

        // Round-robin from rr_ptr = 0, then source 2 ahead of source 0
        cycle('0, '0, '0, 1'b0, 1'b0);
        bcast_log.delete();
        cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'd33, 32'd22, 32'd11}, 1'b1, 1'b0);
        idle(4);
        cycle(3'b010, {5'd0, 5'd10, 5'd0}, {32'd0, 32'd100, 32'd0}, 1'b1, 1'b0);
        idle(3);
        cycle(3'b101, {5'd6, 5'd0, 5'd4}, {32'd66, 32'd0, 32'd44}, 1'b1, 1'b0);
        idle(4);
        settle();
        want = '{1, 2, 3, 10, 6, 4};
        check_log("rr_order", want);

        // Full FIFO on source 0 while sources 1 and 2 win arbitration
        cycle('0, '0, '0, 1'b0, 1'b0);
        bcast_log.delete();
        cycle(3'b001, {5'd0, 5'd0, 5'd11}, {32'd0, 32'd0, 32'd111}, 1'b1, 1'b0);
        cycle(3'b110, {5'd13, 5'd12, 5'd0}, {32'd113, 32'd112, 32'd0}, 1'b1, 1'b0);
        cycle(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'd107}, 1'b1, 1'b0);
        cycle(3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'd108}, 1'b1, 1'b0);
        cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'd109}, 1'b1, 1'b0);
        check("stall_full", 64'(obs_stall), 64'd1);
        cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'd109}, 1'b1, 1'b0);
        check("stall_release", 64'(obs_stall), 64'd0);
        idle(4);
        settle();
        want = '{11, 12, 13, 7, 8, 9};
        check_log("stall_order", want);

        // Zero lock index is dropped
        bcast_log.delete();
        cycle(3'b010, '0, {32'd0, 32'hdead_beef, 32'd0}, 1'b1, 1'b0);
        idle(3);
        settle();
        want.delete();
        check_log("index0_drop", want);

        // Flush two buffered entries; rr_ptr (1 here) must survive the flush
        bcast_log.delete();
        cycle(3'b011, {5'd0, 5'd21, 5'd20}, {32'd0, 32'd121, 32'd120}, 1'b1, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b1);
        idle(2);
        check("flush_stall", 64'(obs_stall), 64'd0);
        settle();
        want.delete();
        check_log("flush_quiet", want);
        cycle(3'b111, {5'd32 - 5'd1, 5'd31 - 5'd0, 5'd30}, {32'd132, 32'd131, 32'd130}, 1'b1, 1'b0);
        idle(4);
        settle();
        want = '{31, 31, 30};
        check_log("flush_rr_held", want);

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            v = 3'($urandom_range(0, 7));
            for (int s = 0; s < N_SRC; s++) idx[s*LOCK_W +: LOCK_W] = 5'($urandom_range(0, 31));
            cycle(v, idx, {$urandom(), $urandom(), $urandom()},
                  ($urandom_range(0, 149) != 0), ($urandom_range(0, 39) == 0));
        end
        idle(6);
        settle();
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
